// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the pipeline-PE driver slice.
package pipe_pkg;

  localparam int N_DEFAULT = 64;
  localparam int LAT_MAX   = 16;
  localparam int STAT_W    = 32;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/pipe_res_fifo.sv
// Synchronous result FIFO: registered write, head visible combinationally on rd_data.
module pipe_res_fifo
  import pipe_pkg::*;
#(
  parameter int N     = N_DEFAULT,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [N-1:0]             wr_data,
  input  logic                     pop,
  output logic [N-1:0]             rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [clog2(DEPTH):0]    count
);

  localparam int AW = clog2(DEPTH);

  logic [N-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = mem[rd_ptr];

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pipe_pe_driver.sv
// Initiator end of the trigger/cts pipelined-PE protocol with credit-protected result FIFO.
// Optional PIPE_DRV_STATS_EN adds saturating issue/stall counters.
module pipe_pe_driver
  import pipe_pkg::*;
#(
  parameter int N     = N_DEFAULT,
  parameter int LAT   = 1,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [N-1:0]      s_in1,
  input  logic [N-1:0]      s_in2,
  output logic              pe_trigger,
  input  logic              pe_cts,
  output logic [N-1:0]      pe_in1,
  output logic [N-1:0]      pe_in2,
  input  logic [N-1:0]      pe_out,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [N-1:0]      m_data,
  output logic              busy
`ifdef PIPE_DRV_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_issued,
  output logic [STAT_W-1:0] stat_stall
`endif
);

  localparam int CW = clog2(DEPTH) + 1;

  // Handshakes: a transfer happens in every cycle where valid & ready are both high;
  // the source holds its payload stable while valid is high and ready is low.
  logic [CW-1:0]            credit;
  logic [LAT-1:0]           tags;
  logic                     issue;
  logic                     pop;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [clog2(DEPTH):0]    fifo_count_unused;

  // Credit covers in-flight tags plus FIFO contents, so a tag can never find the FIFO full.
  assign s_ready    = rst & pe_cts & (credit < CW'(DEPTH));
  assign issue      = s_valid & s_ready;
  assign pe_trigger = issue;
  assign pe_in1     = s_in1;
  assign pe_in2     = s_in2;
  assign m_valid    = ~fifo_empty;
  assign pop        = m_valid & m_ready;
  assign busy       = (credit != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tags <= '0;
    end else begin
      tags[0] <= issue;
      for (int i = 1; i < LAT; i++) tags[i] <= tags[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      credit <= '0;
    end else begin
      case ({issue, pop})
        2'b10:   credit <= credit + CW'(1);
        2'b01:   credit <= credit - CW'(1);
        default: credit <= credit;
      endcase
    end
  end

  pipe_res_fifo #(
    .N     (N),
    .DEPTH (DEPTH)
  ) u_res_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (tags[LAT-1] & ~fifo_full),
    .wr_data (pe_out),
    .pop     (pop),
    .rd_data (m_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count_unused)
  );

`ifdef PIPE_DRV_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_issued <= '0;
      stat_stall  <= '0;
    end else begin
      if (issue && (stat_issued != '1))
        stat_issued <= stat_issued + STAT_W'(1);
      if (s_valid && !s_ready && (stat_stall != '1))
        stat_stall <= stat_stall + STAT_W'(1);
    end
  end
`else
  // Statistics counters are compiled out in this build.
`endif

endmodule

// File: tb/tb_pipe_pe_driver.sv
// Self-checking bench for pipe_pe_driver: queue-based reference model plus directed literal checks.
module tb_pipe_pe_driver;

  localparam int N     = 64;
  localparam int LAT   = 1;
  localparam int DEPTH = 4;

  logic         clk;
  logic         rst;
  logic         s_valid;
  logic         s_ready;
  logic [N-1:0] s_in1;
  logic [N-1:0] s_in2;
  logic         pe_trigger;
  logic         pe_cts;
  logic [N-1:0] pe_in1;
  logic [N-1:0] pe_in2;
  logic [N-1:0] pe_out;
  logic         m_valid;
  logic         m_ready;
  logic [N-1:0] m_data;
  logic         busy;
`ifdef PIPE_DRV_STATS_EN
  logic [31:0]  stat_issued;
  logic [31:0]  stat_stall;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  pipe_pe_driver #(.N(N), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_in1      (s_in1),
    .s_in2      (s_in2),
    .pe_trigger (pe_trigger),
    .pe_cts     (pe_cts),
    .pe_in1     (pe_in1),
    .pe_in2     (pe_in2),
    .pe_out     (pe_out),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .busy       (busy)
`ifdef PIPE_DRV_STATS_EN
    ,
    .stat_issued(stat_issued),
    .stat_stall (stat_stall)
`endif
  );

  // Clock and PE model: registered adder, LAT stages deep.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0] pe_pipe [LAT];
  always @(posedge clk) begin
    pe_pipe[0] <= pe_in1 + pe_in2;
    for (int i = 1; i < LAT; i++) pe_pipe[i] <= pe_pipe[i-1];
  end
  assign pe_out = pe_pipe[LAT-1];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: every accepted pair is a pending result that becomes
  // visible LAT+1 cycles after acceptance; pending count is the credit.
  logic [N-1:0] exp_q [$];
  int           rdy_q [$];
  int           cyc = 0;
  int           m_issued = 0;
  int           m_stall = 0;

  always @(negedge clk) begin
    logic exp_sr;
    logic exp_mv;
    if (!rst) begin
      exp_q.delete();
      rdy_q.delete();
      m_issued = 0;
      m_stall  = 0;
      chk("rst_trigger", pe_trigger, 0);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_busy", busy, 0);
    end else begin
      exp_sr = pe_cts && (exp_q.size() < DEPTH);
      exp_mv = (exp_q.size() > 0) && (rdy_q[0] <= cyc);
      chk("s_ready", s_ready, exp_sr);
      chk("pe_trigger", pe_trigger, s_valid && exp_sr);
      if (s_valid) begin
        chk("pe_in1", pe_in1, s_in1);
        chk("pe_in2", pe_in2, s_in2);
      end
      chk("m_valid", m_valid, exp_mv);
      if (exp_mv) chk("m_data", m_data, exp_q[0]);
      chk("busy", busy, exp_q.size() != 0);
      if (exp_mv && m_ready) begin
        void'(exp_q.pop_front());
        void'(rdy_q.pop_front());
      end
      if (s_valid && exp_sr) begin
        exp_q.push_back(s_in1 + s_in2);
        rdy_q.push_back(cyc + LAT + 1);
        m_issued++;
      end
      if (s_valid && !exp_sr) m_stall++;
    end
`ifdef PIPE_DRV_STATS_EN
    chk("stat_issued", stat_issued, m_issued);
    chk("stat_stall", stat_stall, m_stall);
`endif
    cyc++;
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [N-1:0] a, input logic [N-1:0] b, output bit ok);
    bit acc;
    ok = 0;
    s_valid = 1'b1;
    s_in1   = a;
    s_in2   = b;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      acc = s_ready;
      tick();
      if (acc) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("offer_timeout", 0, 1);
  endtask

  task automatic drain();
    bit idle;
    idle = 0;
    s_valid = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) begin
        idle = 1;
        break;
      end
      tick();
    end
    chk("drain_idle", idle, 1);
    tick();
  endtask

  initial begin
    bit ok;
    bit acc;
    int k;
    int n_acc;
    rst = 1'b0;
    s_valid = 1'b0;
    s_in1 = '0;
    s_in2 = '0;
    pe_cts = 1'b1;
    m_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_m_valid", m_valid, 0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_s_ready", s_ready, 1);
    tick();

    // Single op 3+4
    s_valid = 1'b1; s_in1 = 3; s_in2 = 4;
    @(negedge clk);
    chk("single_trigger", pe_trigger, 1);
    tick();
    s_valid = 1'b0;
    @(negedge clk);
    chk("single_t1_m_valid", m_valid, 0);
    tick();
    @(negedge clk);
    chk("single_t2_m_valid", m_valid, 1);
    chk("single_t2_m_data", m_data, 7);
    tick();
    @(negedge clk);
    chk("single_t3_busy", busy, 0);
    tick();

    // Streaming 16 back-to-back pairs (i, 2i)
    for (int i = 0; i < 16; i++) begin
      s_valid = 1'b1; s_in1 = N'(i); s_in2 = N'(2 * i);
      @(negedge clk);
      chk("stream_s_ready", s_ready, 1);
      tick();
    end
    drain();

    // Back-pressure: six pairs offered with m_ready low
    m_ready = 1'b0;
    k = 0;
    n_acc = 0;
    for (int i = 0; i < 8; i++) begin
      s_valid = 1'b1; s_in1 = N'(10 + k); s_in2 = N'(k);
      @(negedge clk);
      acc = s_ready;
      tick();
      if (acc) begin
        n_acc++;
        k++;
      end
    end
    chk("bp_accepted", n_acc, 4);
    @(negedge clk);
    chk("bp_s_ready_low", s_ready, 0);
    tick();
    m_ready = 1'b1;
    while (k < 6) begin
      offer(N'(10 + k), N'(k), ok);
      if (!ok) break;
      k++;
    end
    drain();

    // cts stall with operands held
    pe_cts = 1'b0;
    s_valid = 1'b1; s_in1 = 100; s_in2 = 5;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("cts_stall_trigger", pe_trigger, 0);
      tick();
    end
    pe_cts = 1'b1;
    @(negedge clk);
    chk("cts_resume_trigger", pe_trigger, 1);
    chk("cts_resume_pe_in1", pe_in1, 100);
    tick();
    drain();

    // Randomized traffic
    s_valid = 1'b0;
    acc = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!s_valid || acc) begin
        s_valid = ($urandom_range(0, 3) != 0);
        s_in1 = {$urandom, $urandom};
        s_in2 = {$urandom, $urandom};
      end
      pe_cts  = ($urandom_range(0, 4) != 0);
      m_ready = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      acc = s_valid && s_ready;
      tick();
    end
    pe_cts = 1'b1;
    drain();

    // Reset with three operations in flight
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) offer(N'(20 + i), N'(i), ok);
    s_valid = 1'b1; s_in1 = 9; s_in2 = 9;
    rst = 1'b0;
    #1;
    chk("midrst_m_valid", m_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_trigger", pe_trigger, 0);
    tick();
    tick();
    s_valid = 1'b0;
    rst = 1'b1;
    m_ready = 1'b1;
    tick();
    offer(1, 1, ok);
    s_valid = 1'b0;
    acc = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (m_valid) begin
        acc = 1'b1;
        chk("postrst_m_data", m_data, 2);
        tick();
        break;
      end
      tick();
    end
    chk("postrst_result_seen", acc, 1);
    @(negedge clk);
    chk("postrst_no_extra", m_valid, 0);
    tick();

`ifdef PIPE_DRV_STATS_EN
    // Stats: 4 stall cycles then 10 issues from a fresh reset
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    pe_cts = 1'b0;
    s_valid = 1'b1; s_in1 = 1; s_in2 = 2;
    repeat (4) tick();
    pe_cts = 1'b1;
    for (int i = 0; i < 10; i++) begin
      s_in1 = N'(i);
      tick();
    end
    s_valid = 1'b0;
    @(negedge clk);
    chk("stats_issued_10", stat_issued, 10);
    chk("stats_stall_4", stat_stall, 4);
    tick();
`endif

    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
